// File: rtl/wbm_arbiter.sv
// wbm_arbiter: two-master (I = fetch, D = load/store), one-slave arbiter
// for a 16-bit pipelined Wishbone B.4 master port.
//
// Ports:
//   clk_i, reset_i            clock, asynchronous active-high reset
//   i*/d* inputs              per-master cyc/stb/we/adr/dat requests
//   iack_o/dack_o             per-master acknowledge (owner only)
//   idat_o/ddat_o             read data broadcast to both masters
//   wbm* outputs/inputs       shared external Wishbone bus
//   gnt_o                     {D owns, I owns}; 00 = idle
//   err_o                     sticky protocol-violation flag
//
// A strobe from a master that cannot issue this cycle is parked in a
// one-deep pending buffer and replayed once that master owns the bus.
module wbm_arbiter #(
  parameter int unsigned AW     = 64,
  parameter int unsigned DW     = 16,
  parameter bit          PRIO_D = 1'b1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          icyc_i,
  input  logic          istb_i,
  input  logic          iwe_i,
  input  logic [AW-1:0] iadr_i,
  input  logic [DW-1:0] idat_i,
  output logic          iack_o,
  output logic [DW-1:0] idat_o,
  input  logic          dcyc_i,
  input  logic          dstb_i,
  input  logic          dwe_i,
  input  logic [AW-1:0] dadr_i,
  input  logic [DW-1:0] ddat_i,
  output logic          dack_o,
  output logic [DW-1:0] ddat_o,
  output logic          wbmcyc_o,
  output logic          wbmstb_o,
  output logic          wbmwe_o,
  output logic [AW-1:0] wbmadr_o,
  output logic [DW-1:0] wbmdat_o,
  input  logic          wbmack_i,
  input  logic [DW-1:0] wbmdat_i,
  output logic [1:0]    gnt_o,
  output logic          err_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_I = 2'd1,
    ST_OWN_D = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          ipend_v_q, ipend_v_d, ipend_we_q, ipend_we_d;
  logic [AW-1:0] ipend_adr_q, ipend_adr_d;
  logic [DW-1:0] ipend_dat_q, ipend_dat_d;
  logic          dpend_v_q, dpend_v_d, dpend_we_q, dpend_we_d;
  logic [AW-1:0] dpend_adr_q, dpend_adr_d;
  logic [DW-1:0] dpend_dat_q, dpend_dat_d;
  logic [1:0]    outst_q, outst_d;
  logic          err_q, err_d;

  logic          own_i, own_d;
  logic          drain_i, drain_d, full_i, full_d;
  logic          bus_stb, bus_we;
  logic [AW-1:0] bus_adr;
  logic [DW-1:0] bus_dat;

  always_comb begin
    own_i   = (state_q == ST_OWN_I);
    own_d   = (state_q == ST_OWN_D);
    drain_i = own_i & ipend_v_q;
    drain_d = own_d & dpend_v_q;
    // Buffer stays occupied this cycle unless it is being replayed.
    full_i  = ipend_v_q & ~drain_i;
    full_d  = dpend_v_q & ~drain_d;

    // Bus issue: replay has priority over the owner's live strobe.
    bus_stb = 1'b0;
    bus_we  = 1'b0;
    bus_adr = '0;
    bus_dat = '0;
    if (own_i) begin
      if (ipend_v_q) begin
        bus_stb = 1'b1;
        bus_we  = ipend_we_q;
        bus_adr = ipend_adr_q;
        bus_dat = ipend_dat_q;
      end else if (istb_i) begin
        bus_stb = 1'b1;
        bus_we  = iwe_i;
        bus_adr = iadr_i;
        bus_dat = idat_i;
      end
    end else if (own_d) begin
      if (dpend_v_q) begin
        bus_stb = 1'b1;
        bus_we  = dpend_we_q;
        bus_adr = dpend_adr_q;
        bus_dat = dpend_dat_q;
      end else if (dstb_i) begin
        bus_stb = 1'b1;
        bus_we  = dwe_i;
        bus_adr = dadr_i;
        bus_dat = ddat_i;
      end
    end

    err_d = err_q;

    // Pending buffers: a strobe not issued directly is captured; if the
    // buffer is still occupied the request is dropped and flagged.
    ipend_v_d   = ipend_v_q & ~drain_i;
    ipend_we_d  = ipend_we_q;
    ipend_adr_d = ipend_adr_q;
    ipend_dat_d = ipend_dat_q;
    if (istb_i && !(own_i && !ipend_v_q)) begin
      if (full_i) begin
        err_d = 1'b1;
      end else begin
        ipend_v_d   = 1'b1;
        ipend_we_d  = iwe_i;
        ipend_adr_d = iadr_i;
        ipend_dat_d = idat_i;
      end
    end

    dpend_v_d   = dpend_v_q & ~drain_d;
    dpend_we_d  = dpend_we_q;
    dpend_adr_d = dpend_adr_q;
    dpend_dat_d = dpend_dat_q;
    if (dstb_i && !(own_d && !dpend_v_q)) begin
      if (full_d) begin
        err_d = 1'b1;
      end else begin
        dpend_v_d   = 1'b1;
        dpend_we_d  = dwe_i;
        dpend_adr_d = dadr_i;
        dpend_dat_d = ddat_i;
      end
    end

    // Outstanding counter saturates on overflow and holds 0 on underflow.
    outst_d = outst_q;
    unique case ({bus_stb, wbmack_i})
      2'b10: begin
        if (outst_q == 2'd3) err_d = 1'b1;
        else                 outst_d = outst_q + 2'd1;
      end
      2'b01: begin
        if (outst_q == 2'd0) err_d = 1'b1;
        else                 outst_d = outst_q - 2'd1;
      end
      default: outst_d = outst_q;
    endcase

    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (dcyc_i && (PRIO_D || !icyc_i)) state_d = ST_OWN_D;
        else if (icyc_i)                   state_d = ST_OWN_I;
      end
      ST_OWN_I: begin
        if (!icyc_i && !ipend_v_q && outst_q == 2'd0)
          state_d = dcyc_i ? ST_OWN_D : ST_IDLE;
      end
      ST_OWN_D: begin
        if (!dcyc_i && !dpend_v_q && outst_q == 2'd0)
          state_d = icyc_i ? ST_OWN_I : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      ipend_v_q   <= 1'b0;
      ipend_we_q  <= 1'b0;
      ipend_adr_q <= '0;
      ipend_dat_q <= '0;
      dpend_v_q   <= 1'b0;
      dpend_we_q  <= 1'b0;
      dpend_adr_q <= '0;
      dpend_dat_q <= '0;
      outst_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ipend_v_q   <= ipend_v_d;
      ipend_we_q  <= ipend_we_d;
      ipend_adr_q <= ipend_adr_d;
      ipend_dat_q <= ipend_dat_d;
      dpend_v_q   <= dpend_v_d;
      dpend_we_q  <= dpend_we_d;
      dpend_adr_q <= dpend_adr_d;
      dpend_dat_q <= dpend_dat_d;
      outst_q     <= outst_d;
      err_q       <= err_d;
    end
  end

  assign wbmcyc_o = (state_q != ST_IDLE);
  assign wbmstb_o = bus_stb;
  assign wbmwe_o  = bus_we;
  assign wbmadr_o = bus_adr;
  assign wbmdat_o = bus_dat;
  assign iack_o   = wbmack_i & own_i;
  assign dack_o   = wbmack_i & own_d;
  // Read data is broadcast, but forced low while reset is asserted.
  assign idat_o   = reset_i ? '0 : wbmdat_i;
  assign ddat_o   = reset_i ? '0 : wbmdat_i;
  assign gnt_o    = {own_d, own_i};
  assign err_o    = err_q;

endmodule

// File: tb/tb_wbm_arbiter.sv
// tb_wbm_arbiter: directed-vector bench for wbm_arbiter (PRIO_D = 1).
module tb_wbm_arbiter;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          icyc_i, istb_i, iwe_i;
  logic [AW-1:0] iadr_i;
  logic [DW-1:0] idat_i;
  logic          iack_o;
  logic [DW-1:0] idat_o;
  logic          dcyc_i, dstb_i, dwe_i;
  logic [AW-1:0] dadr_i;
  logic [DW-1:0] ddat_i;
  logic          dack_o;
  logic [DW-1:0] ddat_o;
  logic          wbmcyc_o, wbmstb_o, wbmwe_o;
  logic [AW-1:0] wbmadr_o;
  logic [DW-1:0] wbmdat_o;
  logic          wbmack_i;
  logic [DW-1:0] wbmdat_i;
  logic [1:0]    gnt_o;
  logic          err_o;

  int unsigned errors = 0;
  int unsigned checks = 0;

  wbm_arbiter #(.AW(AW), .DW(DW), .PRIO_D(1'b1)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .icyc_i(icyc_i), .istb_i(istb_i), .iwe_i(iwe_i), .iadr_i(iadr_i),
    .idat_i(idat_i), .iack_o(iack_o), .idat_o(idat_o),
    .dcyc_i(dcyc_i), .dstb_i(dstb_i), .dwe_i(dwe_i), .dadr_i(dadr_i),
    .ddat_i(ddat_i), .dack_o(dack_o), .ddat_o(ddat_o),
    .wbmcyc_o(wbmcyc_o), .wbmstb_o(wbmstb_o), .wbmwe_o(wbmwe_o),
    .wbmadr_o(wbmadr_o), .wbmdat_o(wbmdat_o), .wbmack_i(wbmack_i),
    .wbmdat_i(wbmdat_i), .gnt_o(gnt_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_i = 1'b1;
    icyc_i = 0; istb_i = 0; iwe_i = 0; iadr_i = '0; idat_i = '0;
    dcyc_i = 0; dstb_i = 0; dwe_i = 0; dadr_i = '0; ddat_i = '0;
    wbmack_i = 0; wbmdat_i = '0;
    #3;
    check("rst_cyc", wbmcyc_o, 0);
    check("rst_gnt", gnt_o, 0);
    check("rst_err", err_o, 0);
    tick(); tick();
    reset_i = 1'b0;

    // Simultaneous requests in IDLE: D wins, its strobe is replayed next cycle.
    tick();
    icyc_i = 1; dcyc_i = 1; dstb_i = 1; dadr_i = 64'h1000;
    #1;
    check("idle_stb", wbmstb_o, 0);
    check("idle_gnt", gnt_o, 0);

    // First OWN_D cycle; I strobes 0x2000 and is parked.
    tick();
    dstb_i = 0; dadr_i = '0; istb_i = 1; iadr_i = 64'h2000;
    #1;
    check("prio_gnt", gnt_o, 2'b10);
    check("prio_stb", wbmstb_o, 1);
    check("prio_adr", wbmadr_o, 64'h1000);
    check("prio_iack", iack_o, 0);

    // D drops cyc, ack arrives.
    tick();
    istb_i = 0; iadr_i = '0; dcyc_i = 0; wbmack_i = 1; wbmdat_i = 16'h1234;
    #1;
    check("d_ack", dack_o, 1);
    check("d_iack0", iack_o, 0);
    check("d_dat", ddat_o, 16'h1234);
    check("d_hold_gnt", gnt_o, 2'b10);

    // Outstanding now 0: release evaluated this cycle, bus idle within cyc.
    tick();
    wbmack_i = 0;
    #1;
    check("rel_gnt", gnt_o, 2'b10);
    check("rel_cyc", wbmcyc_o, 1);
    check("rel_stb", wbmstb_o, 0);
    check("rel_adr0", wbmadr_o, 0);

    // Hand-off to I without IDLE, replay of 0x2000.
    tick();
    #1;
    check("hand_gnt", gnt_o, 2'b01);
    check("hand_stb", wbmstb_o, 1);
    check("hand_adr", wbmadr_o, 64'h2000);
    tick();
    tick();
    wbmack_i = 1;
    #1;
    check("hand_iack", iack_o, 1);
    check("hand_dack0", dack_o, 0);

    // Pass-through read at 0x40.
    tick();
    wbmack_i = 0; istb_i = 1; iadr_i = 64'h40;
    #1;
    check("pt_stb", wbmstb_o, 1);
    check("pt_adr", wbmadr_o, 64'h40);
    tick();
    istb_i = 0; iadr_i = '0;
    tick();
    wbmack_i = 1; wbmdat_i = 16'hBEEF;
    #1;
    check("pt_iack", iack_o, 1);
    check("pt_idat", idat_o, 16'hBEEF);
    check("pt_dack0", dack_o, 0);

    // I releases to D; D strobe 0x10 parked during OWN_I.
    tick();
    wbmack_i = 0; icyc_i = 0; dcyc_i = 1; dstb_i = 1; dadr_i = 64'h10;
    #1;
    check("rr_pre_gnt", gnt_o, 2'b01);
    check("rr_pre_stb", wbmstb_o, 0);

    // Replay-and-refill.
    tick();
    dadr_i = 64'h12;
    #1;
    check("rr_gnt", gnt_o, 2'b10);
    check("rr_stb", wbmstb_o, 1);
    check("rr_adr0", wbmadr_o, 64'h10);
    check("rr_err0", err_o, 0);
    tick();
    dstb_i = 0; dadr_i = '0;
    #1;
    check("rr_stb1", wbmstb_o, 1);
    check("rr_adr1", wbmadr_o, 64'h12);
    check("rr_err1", err_o, 0);
    tick(); wbmack_i = 1;
    tick();
    tick(); wbmack_i = 0; dcyc_i = 0;
    tick();
    #1;
    check("rr_idle_gnt", gnt_o, 0);
    check("rr_idle_cyc", wbmcyc_o, 0);
    check("rr_idle_err", err_o, 0);

    // Double strobe while pending_I full and not draining.
    istb_i = 1; iadr_i = 64'h50;
    tick();
    iadr_i = 64'h60;
    #1;
    check("ovr_err_pre", err_o, 0);
    tick();
    istb_i = 0; iadr_i = '0;
    #1;
    check("ovr_err", err_o, 1);
    tick(); tick();
    check("ovr_sticky", err_o, 1);

    reset_i = 1;
    #1;
    check("rst2_err", err_o, 0);
    tick();
    reset_i = 0;

    // Spurious ack in IDLE.
    tick();
    wbmack_i = 1;
    tick();
    wbmack_i = 0;
    #1;
    check("spur_err", err_o, 1);

    // Reset in the middle of a D transfer.
    dcyc_i = 1; dstb_i = 1; dadr_i = 64'h70;
    tick();
    dstb_i = 0; dadr_i = '0;
    #1;
    check("mid_stb", wbmstb_o, 1);
    check("mid_gnt", gnt_o, 2'b10);
    #2;
    reset_i = 1; wbmdat_i = 16'h5555;
    #1;
    check("mid_rst_cyc", wbmcyc_o, 0);
    check("mid_rst_stb", wbmstb_o, 0);
    check("mid_rst_gnt", gnt_o, 0);
    check("mid_rst_err", err_o, 0);
    check("mid_rst_idat", idat_o, 0);
    tick();
    dcyc_i = 0; reset_i = 0; wbmdat_i = '0;
    tick();
    #1;
    check("post_rst_gnt", gnt_o, 0);
    check("post_rst_cyc", wbmcyc_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
